// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: FSM states, RV32I load/store
// funct3 encodings and the latched request record.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [31:0] addr;
    logic        wren;
    logic [2:0]  funct3;
    logic [31:0] wdata;
  } req_t;

  // Stores only have signed encodings; the unsigned forms are load-only.
  function automatic logic f3_legal(input logic wren, input logic [2:0] f3);
    logic ok;
    ok = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (!wren) begin
      ok = ok || (f3 == F3_BU) || (f3 == F3_HU);
    end
    return ok;
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane formatting for one access: store byte enables and merged word,
// sign/zero-extended load data, and the natural-alignment check.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  byte_en,
  output logic [31:0] store_word,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] store_lanes;
  logic [31:0] rword_sh;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  assign rword_sh = rword >> {offset, 3'b000};
  assign sel_byte = rword_sh[7:0];
  assign sel_half = offset[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    byte_en     = 4'b0000;
    store_lanes = wdata;
    load_data   = 32'h0;
    misalign    = 1'b0;
    unique case (funct3)
      F3_B, F3_BU: begin
        byte_en     = 4'b0001 << offset;
        store_lanes = {4{wdata[7:0]}};
        load_data   = (funct3 == F3_B) ? {{24{sel_byte[7]}}, sel_byte} : {24'h0, sel_byte};
      end
      F3_H, F3_HU: begin
        byte_en     = offset[1] ? 4'b1100 : 4'b0011;
        store_lanes = {2{wdata[15:0]}};
        load_data   = (funct3 == F3_H) ? {{16{sel_half[15]}}, sel_half} : {16'h0, sel_half};
        misalign    = offset[0];
      end
      F3_W: begin
        byte_en   = 4'b1111;
        load_data = rword;
        misalign  = (offset != 2'b00);
      end
      default: begin
        byte_en = 4'b0000;
      end
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign store_word[8*gi +: 8] = byte_en[gi] ? store_lanes[8*gi +: 8] : rword[8*gi +: 8];
    end
  endgenerate

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with valid/ready request and response channels and
// programmable wait states. Define DMEM_BACK_TO_BACK_EN to overlap response completion with the next accept.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 2048,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_2000
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_vld,
  output logic        o_req_rdy,
  input  logic [31:0] i_req_addr,
  input  logic        i_req_wren,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_vld,
  input  logic        i_rsp_rdy,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int          IDX_W     = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN      = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WAIT_LAST = 4'(WAIT_CYCLES);

  logic [31:0] mem [DEPTH_WORDS];

  state_t      state_reg, state_next;
  logic [3:0]  wait_cnt_reg, wait_cnt_next;
  req_t        req_reg, req_in, acc_req;
  logic [31:0] rsp_rdata_reg;
  logic        rsp_err_reg;
  logic        accept, access, cnt_done;

  logic [31:0]      acc_off;
  logic [IDX_W-1:0] acc_idx;
  logic [31:0]      acc_rword;
  logic [3:0]       byte_en;
  logic [31:0]      store_word, load_data;
  logic             misalign, acc_err;

  assign req_in = {i_req_addr, i_req_wren, i_req_funct3, i_req_wdata};

  // With no wait states the array is accessed on the accepting edge itself,
  // before the request register has been loaded.
  assign acc_req   = (WAIT_CYCLES == 0) ? req_in : req_reg;
  assign acc_off   = acc_req.addr - BASE_ADDR;
  assign acc_idx   = acc_off[IDX_W+1:2];
  assign acc_rword = mem[acc_idx];
  assign acc_err   = (acc_off >= SPAN) || misalign || !f3_legal(acc_req.wren, acc_req.funct3);
  assign cnt_done  = (wait_cnt_reg == WAIT_LAST);

  dmem_lane_fmt u_lane_fmt (
    .funct3     (acc_req.funct3),
    .offset     (acc_off[1:0]),
    .wdata      (acc_req.wdata),
    .rword      (acc_rword),
    .byte_en    (byte_en),
    .store_word (store_word),
    .load_data  (load_data),
    .misalign   (misalign)
  );

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    o_req_rdy     = 1'b0;
    o_rsp_vld     = 1'b0;
    access        = 1'b0;
    unique case (state_reg)
      IDLE: begin
        o_req_rdy = 1'b1;
      end
      WAIT: begin
        if (cnt_done) begin
          state_next    = RESP;
          wait_cnt_next = 4'd0;
          access        = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 4'd1;
        end
      end
      RESP: begin
        o_rsp_vld = 1'b1;
`ifdef DMEM_BACK_TO_BACK_EN
        o_req_rdy = i_rsp_rdy;
`endif
        if (i_rsp_rdy) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    accept = i_req_vld && o_req_rdy;
    if (accept) begin
      if (WAIT_CYCLES == 0) begin
        state_next = RESP;
        access     = 1'b1;
      end else begin
        state_next    = WAIT;
        wait_cnt_next = 4'd1;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg     <= IDLE;
      wait_cnt_reg  <= 4'd0;
      req_reg       <= '0;
      rsp_rdata_reg <= 32'h0;
      rsp_err_reg   <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (accept) begin
        req_reg <= req_in;
      end
      if (access) begin
        rsp_err_reg   <= acc_err;
        rsp_rdata_reg <= (acc_err || acc_req.wren) ? 32'h0 : load_data;
      end
    end
  end

  // The array has no reset; the explicit reset gate stops a zero-wait accept
  // from committing a store while reset is held.
  always_ff @(posedge i_clk) begin
    if (access && !i_rst && !acc_err && acc_req.wren) begin
      mem[acc_idx] <= store_word;
    end
  end

  assign o_rsp_rdata = rsp_rdata_reg;
  assign o_rsp_err   = rsp_err_reg;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a vector table of load/store accesses with
// hand-computed results, plus backpressure and mid-transaction reset sequences.
module tb_dmem_responder;
  import dmem_pkg::*;

  localparam int WAIT = 2;
`ifdef DMEM_BACK_TO_BACK_EN
  localparam bit B2B = 1'b1;
`else
  localparam bit B2B = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_vld = 1'b0;
  logic        req_rdy;
  logic [31:0] req_addr = 32'h0;
  logic        req_wren = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_wdata = 32'h0;
  logic        rsp_vld;
  logic        rsp_rdy = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dmem_responder #(
    .DEPTH_WORDS (2048),
    .WAIT_CYCLES (WAIT),
    .BASE_ADDR   (32'h0000_2000)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_vld    (req_vld),
    .o_req_rdy    (req_rdy),
    .i_req_addr   (req_addr),
    .i_req_wren   (req_wren),
    .i_req_funct3 (req_funct3),
    .i_req_wdata  (req_wdata),
    .o_rsp_vld    (rsp_vld),
    .i_rsp_rdy    (rsp_rdy),
    .o_rsp_rdata  (rsp_rdata),
    .o_rsp_err    (rsp_err)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic        wren;
    logic [2:0]  f3;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string nm, input logic [31:0] a, input logic w, input logic [2:0] f3,
                     input logic [31:0] wd, input logic [31:0] er, input logic ee);
    vec_t v;
    v.name = nm; v.addr = a; v.wren = w; v.f3 = f3; v.wdata = wd; v.exp_rdata = er; v.exp_err = ee;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns the same way.
  task automatic txn(input logic [31:0] a, input logic w, input logic [2:0] f3, input logic [31:0] wd,
                     input bit early_rdy, output logic [31:0] rd, output logic er, output int lat);
    int g;
    req_addr = a; req_wren = w; req_funct3 = f3; req_wdata = wd; req_vld = 1'b1;
    g = 0;
    while (!req_rdy && g < 20) begin
      @(posedge clk); #1; g++;
    end
    if (g >= 20) chk("accept_timeout", 32'(g), 32'(0));
    @(posedge clk); #1;
    // Garbage on the request bus must not affect the accepted access.
    req_vld = 1'b0; req_addr = $urandom; req_wren = 1'b1;
    req_funct3 = 3'($urandom_range(0, 7)); req_wdata = $urandom;
    rsp_rdy = early_rdy;
    lat = 1;
    while (!rsp_vld && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    if (!rsp_vld) chk("rsp_timeout", 32'(lat), 32'(WAIT + 1));
    rd = rsp_rdata; er = rsp_err;
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          g;

    add("SW_2000",    32'h2000, 1'b1, F3_W,   32'hDEADBEEF, 32'h0,        1'b0);
    add("LW_2000",    32'h2000, 1'b0, F3_W,   32'h0,        32'hDEADBEEF, 1'b0);
    add("SB_2001",    32'h2001, 1'b1, F3_B,   32'hABCDEF55, 32'h0,        1'b0);
    add("LB_2001",    32'h2001, 1'b0, F3_B,   32'h0,        32'h00000055, 1'b0);
    add("LW_merged",  32'h2000, 1'b0, F3_W,   32'h0,        32'hDEAD55EF, 1'b0);
    add("LBU_2003",   32'h2003, 1'b0, F3_BU,  32'h0,        32'h000000DE, 1'b0);
    add("LB_2003",    32'h2003, 1'b0, F3_B,   32'h0,        32'hFFFFFFDE, 1'b0);
    add("LH_2002",    32'h2002, 1'b0, F3_H,   32'h0,        32'hFFFFDEAD, 1'b0);
    add("LHU_2002",   32'h2002, 1'b0, F3_HU,  32'h0,        32'h0000DEAD, 1'b0);
    add("LH_2000",    32'h2000, 1'b0, F3_H,   32'h0,        32'h000055EF, 1'b0);
    add("LH_odd",     32'h2001, 1'b0, F3_H,   32'h0,        32'h0,        1'b1);
    add("SW_mis",     32'h2002, 1'b1, F3_W,   32'h11111111, 32'h0,        1'b1);
    add("LW_mis",     32'h2001, 1'b0, F3_W,   32'h0,        32'h0,        1'b1);
    add("LW_unchg",   32'h2000, 1'b0, F3_W,   32'h0,        32'hDEAD55EF, 1'b0);
    add("LW_below",   32'h1FFC, 1'b0, F3_W,   32'h0,        32'h0,        1'b1);
    add("LW_above",   32'h4000, 1'b0, F3_W,   32'h0,        32'h0,        1'b1);
    add("LD_f3_011",  32'h2000, 1'b0, 3'b011, 32'h0,        32'h0,        1'b1);
    add("ST_f3_100",  32'h2000, 1'b1, 3'b100, 32'h0,        32'h0,        1'b1);
    add("LW_nowr",    32'h2000, 1'b0, F3_W,   32'h0,        32'hDEAD55EF, 1'b0);
    add("SW_2004",    32'h2004, 1'b1, F3_W,   32'h0BADF00D, 32'h0,        1'b0);
    add("SH_2006",    32'h2006, 1'b1, F3_H,   32'h1234CAFE, 32'h0,        1'b0);
    add("LW_2004",    32'h2004, 1'b0, F3_W,   32'h0,        32'hCAFEF00D, 1'b0);
    add("LHU_2006",   32'h2006, 1'b0, F3_HU,  32'h0,        32'h0000CAFE, 1'b0);
    add("LB_2006",    32'h2006, 1'b0, F3_B,   32'h0,        32'hFFFFFFFE, 1'b0);
    add("SW_last",    32'h3FFC, 1'b1, F3_W,   32'hA5A50001, 32'h0,        1'b0);
    add("LW_last",    32'h3FFC, 1'b0, F3_W,   32'h0,        32'hA5A50001, 1'b0);
    add("LB_3FFF",    32'h3FFF, 1'b0, F3_B,   32'h0,        32'hFFFFFFA5, 1'b0);

    // Reset state while reset is held.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rsp_vld", {31'b0, rsp_vld}, 32'h0);
    chk("rst_req_rdy", {31'b0, req_rdy}, 32'h1);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", {31'b0, rsp_err}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      txn(vecs[i].addr, vecs[i].wren, vecs[i].f3, vecs[i].wdata, (i % 2) == 1, rd, er, lat);
      $display("txn %0d %s addr=%08h rdata=%08h err=%0b lat=%0d", i, vecs[i].name, vecs[i].addr, rd, er, lat);
      chk({vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      chk({vecs[i].name, "_err"}, {31'b0, er}, {31'b0, vecs[i].exp_err});
      chk({vecs[i].name, "_lat"}, 32'(lat), 32'(WAIT + 1));
      chk({vecs[i].name, "_vld_drop"}, {31'b0, rsp_vld}, 32'h0);
    end

    // Backpressure: response held for 5 cycles while a second request waits.
    req_addr = 32'h2000; req_wren = 1'b0; req_funct3 = F3_W; req_vld = 1'b1;
    @(posedge clk); #1;
    req_addr = 32'h3FFC; req_wren = 1'b0; req_funct3 = F3_W; req_wdata = 32'h0;
    g = 0;
    while (!rsp_vld && g < 20) begin
      @(posedge clk); #1; g++;
    end
    for (int c = 0; c < 5; c++) begin
      $display("txn hold cycle=%0d vld=%0b rdata=%08h err=%0b req_rdy=%0b", c, rsp_vld, rsp_rdata, rsp_err, req_rdy);
      chk("hold_vld", {31'b0, rsp_vld}, 32'h1);
      chk("hold_rdata", rsp_rdata, 32'hDEAD55EF);
      chk("hold_err", {31'b0, rsp_err}, 32'h0);
      chk("hold_req_rdy", {31'b0, req_rdy}, 32'h0);
      @(posedge clk); #1;
    end
    rsp_rdy = 1'b1;
    #1;
    chk("release_req_rdy", {31'b0, req_rdy}, {31'b0, B2B});
    @(posedge clk); #1;
    rsp_rdy = 1'b0;
    chk("after_release_vld", {31'b0, rsp_vld}, 32'h0);
    chk("after_release_req_rdy", {31'b0, req_rdy}, {31'b0, !B2B});
    if (!B2B) begin
      @(posedge clk); #1;
    end
    req_vld = 1'b0;
    lat = 1;
    while (!rsp_vld && lat < 40) begin
      @(posedge clk); #1; lat++;
    end
    $display("txn queued LW_3FFC rdata=%08h err=%0b lat=%0d", rsp_rdata, rsp_err, lat);
    chk("queued_lat", 32'(lat), 32'(WAIT + 1));
    chk("queued_rdata", rsp_rdata, 32'hA5A50001);
    rsp_rdy = 1'b1;
    @(posedge clk); #1;
    rsp_rdy = 1'b0;

    // Reset during the wait states of a store: no response, no write.
    req_addr = 32'h2004; req_wren = 1'b1; req_funct3 = F3_W; req_wdata = 32'h12345678; req_vld = 1'b1;
    @(posedge clk); #1;
    req_vld = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("midrst_vld", {31'b0, rsp_vld}, 32'h0);
    chk("midrst_req_rdy", {31'b0, req_rdy}, 32'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("midrst_no_rsp", {31'b0, rsp_vld}, 32'h0);
      @(posedge clk); #1;
    end
    txn(32'h2004, 1'b0, F3_W, 32'h0, 1'b0, rd, er, lat);
    $display("txn after_reset LW_2004 rdata=%08h err=%0b lat=%0d", rd, er, lat);
    chk("midrst_lw_rdata", rd, 32'hCAFEF00D);
    chk("midrst_lw_err", {31'b0, er}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
